// File: rtl/io_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : io_bridge_pkg                                                     |
// | Purpose : Shared definitions for the VexRiscv IO bridge: register indices, |
// |           status-word bit positions and the machine-timer compare reset.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package io_bridge_pkg;

  // Word index of each IO register. PWM duty registers occupy
  // REG_PWM_BASE .. REG_PWM_BASE+NUM_PWM-1.
  typedef enum logic [7:0] {
    REG_SCRATCH   = 8'd0,
    REG_UART_TX   = 8'd1,
    REG_UART_RX   = 8'd2,
    REG_UART_STAT = 8'd3,
    REG_GPIO_OUT  = 8'd4,
    REG_GPIO_IN   = 8'd5,
    REG_TIME_LO   = 8'd6,
    REG_TIME_HI   = 8'd7,
    REG_CMP_LO    = 8'd8,
    REG_CMP_HI    = 8'd9,
    REG_IRQ_EN    = 8'd10,
    REG_PWM_BASE  = 8'd11
  } io_reg_e;

  // Status word bit positions
  localparam int TX_FULL_BIT  = 31;
  localparam int TX_EMPTY_BIT = 30;
  localparam int RX_VALID_BIT = 31;
  localparam int RX_OVF_BIT   = 31;
  localparam int TX_OVF_BIT   = 30;

  // mtimecmp powers up at its maximum so the interrupt cannot fire early
  localparam logic [63:0] TIMER_RESET_CMP = '1;

endpackage : io_bridge_pkg
`default_nettype wire

// File: rtl/io_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : io_sync_fifo                                                      |
// | Purpose : Single-clock first-word-fall-through FIFO. Pointers carry one    |
// |           extra MSB so full/empty are distinguished without a counter.     |
// | Ports   : clk, reset (sync, active high), push/wdata, pop/rdata,           |
// |           full, empty, level (0..DEPTH)                                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module io_sync_fifo #(
  parameter int DATA_WL = 8,
  parameter int DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_WL-1:0]         wdata,
  input  logic                       pop,
  output logic [DATA_WL-1:0]         rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
  logic [DATA_WL-1:0]  mem_q [DEPTH];
  logic                do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule : io_sync_fifo
`default_nettype wire

// File: rtl/vexriscv_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vexriscv_io_bridge                                                |
// | Purpose : IO-space slave for the VexRiscv dBus: scratch, buffered UART     |
// |           TX/RX FIFOs, GPIO, PWM duty registers and optional machine timer.|
// | Ports   : cmd_* (dBus IO command in), rsp_* (read response, 1 cycle later),|
// |           uart_tx_* / uart_rx_* (uart_lite), gpio_out/gpio_in,            |
// |           pwm_dcycle (packed duties), timer_irq                            |
// | Config  : define IO_BRIDGE_TIMER_EN to build the 64-bit timer, compare and |
// |           IRQ_EN registers; otherwise they read 0 and timer_irq is 0.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module vexriscv_io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DATA_WL      = 32,
  parameter int IO_REG_SPACE = 32,
  parameter int IO_ADDR_WL   = $clog2(IO_REG_SPACE),
  parameter int NUM_PWM      = 4,
  parameter int PWM_WL       = 16,
  parameter int GPIO_OUT_WL  = 8,
  parameter int GPIO_IN_WL   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMER_DIV    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic                      cmd_wr,
  input  logic [IO_ADDR_WL-1:0]     cmd_addr,
  input  logic [DATA_WL-1:0]        cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WL-1:0]        rsp_data,
  input  logic                      uart_tx_rdy,
  output logic                      uart_tx_vld,
  output logic [7:0]                uart_tx_data,
  input  logic                      uart_rx_valid,
  input  logic [7:0]                uart_rx_data,
  output logic [GPIO_OUT_WL-1:0]    gpio_out,
  input  logic [GPIO_IN_WL-1:0]     gpio_in,
  output logic [NUM_PWM*PWM_WL-1:0] pwm_dcycle,
  output logic                      timer_irq
);
  localparam int LVL_WL = $clog2(FIFO_DEPTH) + 1;

  logic [7:0] reg_idx;
  logic       rd_en, wr_en;
  assign reg_idx = 8'(cmd_addr);
  assign rd_en   = cmd_valid && !cmd_wr;
  assign wr_en   = cmd_valid &&  cmd_wr;

  // FIFO interfaces
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_pop, rx_full, rx_empty;
  logic [7:0]        tx_rdata, rx_rdata;
  logic [LVL_WL-1:0] tx_level, rx_level;
  logic              tx_issue;

  // Registers
  logic [DATA_WL-1:0]     scratch_q, scratch_d;
  logic [GPIO_OUT_WL-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_IN_WL-1:0]  gpio_in_q, gpio_in_d;
  logic [PWM_WL-1:0]      pwm_q [NUM_PWM];
  logic [PWM_WL-1:0]      pwm_d [NUM_PWM];
  logic                   tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic                   in_flight_q, in_flight_d;
  logic                   tx_vld_q, tx_vld_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WL-1:0]     rsp_data_q, rsp_data_d;
  logic [DATA_WL-1:0]     rd_mux, timer_rdata;

  io_sync_fifo #(.DATA_WL(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .wdata(cmd_wdata[7:0]),
    .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty),
    .level(tx_level)
  );

  io_sync_fifo #(.DATA_WL(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(uart_rx_valid), .wdata(uart_rx_data),
    .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty),
    .level(rx_level)
  );

  always_comb begin
    scratch_d   = scratch_q;
    gpio_out_d  = gpio_out_q;
    gpio_in_d   = gpio_in;
    pwm_d       = pwm_q;
    tx_ovf_d    = tx_ovf_q;
    rx_ovf_d    = rx_ovf_q;
    rd_mux      = '0;

    // One byte per ready window: in_flight blocks re-issue until uart_lite
    // drops ready to acknowledge it has taken the byte.
    tx_issue    = uart_tx_rdy && !in_flight_q && !tx_empty;
    tx_pop      = tx_issue;
    tx_vld_d    = tx_issue;
    tx_data_d   = tx_issue ? tx_rdata : tx_data_q;
    in_flight_d = tx_issue ? 1'b1 : (uart_tx_rdy ? in_flight_q : 1'b0);

    tx_push = wr_en && (reg_idx == REG_UART_TX) && !tx_full;
    rx_pop  = rd_en && (reg_idx == REG_UART_RX);

    // Status read clears the sticky bits; an overflow in the same cycle wins
    if (rd_en && (reg_idx == REG_UART_STAT)) begin
      tx_ovf_d = 1'b0;
      rx_ovf_d = 1'b0;
    end
    if (wr_en && (reg_idx == REG_UART_TX) && tx_full) tx_ovf_d = 1'b1;
    if (uart_rx_valid && rx_full && !(rx_pop && !rx_empty)) rx_ovf_d = 1'b1;

    if (wr_en) begin
      case (reg_idx)
        REG_SCRATCH:  scratch_d  = cmd_wdata;
        REG_GPIO_OUT: gpio_out_d = cmd_wdata[GPIO_OUT_WL-1:0];
        default: ;
      endcase
      for (int k = 0; k < NUM_PWM; k++) begin
        if (reg_idx == 8'(REG_PWM_BASE) + 8'(k)) pwm_d[k] = cmd_wdata[PWM_WL-1:0];
      end
    end

    case (reg_idx)
      REG_SCRATCH: rd_mux = scratch_q;
      REG_UART_TX: begin
        rd_mux[TX_FULL_BIT]  = tx_full;
        rd_mux[TX_EMPTY_BIT] = tx_empty;
        rd_mux[7:0]          = 8'(tx_level);
      end
      REG_UART_RX: begin
        rd_mux[RX_VALID_BIT] = !rx_empty;
        rd_mux[7:0]          = rx_empty ? 8'h00 : rx_rdata;
      end
      REG_UART_STAT: begin
        rd_mux[RX_OVF_BIT] = rx_ovf_q;
        rd_mux[TX_OVF_BIT] = tx_ovf_q;
        rd_mux[15:8]       = 8'(rx_level);
      end
      REG_GPIO_OUT: rd_mux = DATA_WL'(gpio_out_q);
      REG_GPIO_IN:  rd_mux = DATA_WL'(gpio_in_q);
      REG_TIME_LO, REG_TIME_HI, REG_CMP_LO, REG_CMP_HI, REG_IRQ_EN:
        rd_mux = timer_rdata;
      default: ;
    endcase
    for (int k = 0; k < NUM_PWM; k++) begin
      if (reg_idx == 8'(REG_PWM_BASE) + 8'(k)) rd_mux = DATA_WL'(pwm_q[k]);
    end

    rsp_valid_d = rd_en;
    rsp_data_d  = rd_en ? rd_mux : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q   <= '0;
      gpio_out_q  <= '0;
      gpio_in_q   <= '0;
      for (int k = 0; k < NUM_PWM; k++) pwm_q[k] <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      in_flight_q <= 1'b0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      scratch_q   <= scratch_d;
      gpio_out_q  <= gpio_out_d;
      gpio_in_q   <= gpio_in_d;
      pwm_q       <= pwm_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      in_flight_q <= in_flight_d;
      tx_vld_q    <= tx_vld_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign uart_tx_vld  = tx_vld_q;
  assign uart_tx_data = tx_data_q;
  assign gpio_out     = gpio_out_q;

  for (genvar k = 0; k < NUM_PWM; k++) begin : g_pwm
    assign pwm_dcycle[k*PWM_WL +: PWM_WL] = pwm_q[k];
  end

`ifdef IO_BRIDGE_TIMER_EN
  localparam int DIV_WL = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [DIV_WL-1:0] div_q, div_d;
  logic [63:0]       mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [31:0]       snap_q, snap_d;
  logic              irq_en_q, irq_en_d, timer_irq_q, timer_irq_d;
  logic              tick;

  always_comb begin
    tick       = (div_q == DIV_WL'(TIMER_DIV - 1));
    div_d      = tick ? '0 : div_q + 1'b1;
    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    irq_en_d   = irq_en_q;
    // Reading the low half freezes the high half so a 64-bit read is coherent
    snap_d     = (rd_en && (reg_idx == REG_TIME_LO)) ? mtime_q[63:32] : snap_q;
    if (wr_en) begin
      case (reg_idx)
        REG_TIME_LO: mtime_d[31:0]     = cmd_wdata[31:0];
        REG_TIME_HI: mtime_d[63:32]    = cmd_wdata[31:0];
        REG_CMP_LO:  mtimecmp_d[31:0]  = cmd_wdata[31:0];
        REG_CMP_HI:  mtimecmp_d[63:32] = cmd_wdata[31:0];
        REG_IRQ_EN:  irq_en_d          = cmd_wdata[0];
        default: ;
      endcase
    end
    timer_irq_d = irq_en_q && (mtime_q >= mtimecmp_q);
    timer_rdata = '0;
    case (reg_idx)
      REG_TIME_LO: timer_rdata = DATA_WL'(mtime_q[31:0]);
      REG_TIME_HI: timer_rdata = DATA_WL'(snap_q);
      REG_CMP_LO:  timer_rdata = DATA_WL'(mtimecmp_q[31:0]);
      REG_CMP_HI:  timer_rdata = DATA_WL'(mtimecmp_q[63:32]);
      REG_IRQ_EN:  timer_rdata = DATA_WL'(irq_en_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= TIMER_RESET_CMP;
      snap_q      <= '0;
      irq_en_q    <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      snap_q      <= snap_d;
      irq_en_q    <= irq_en_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign timer_irq = timer_irq_q;
`else
  assign timer_rdata = '0;
  assign timer_irq   = 1'b0;
`endif

endmodule : vexriscv_io_bridge
`default_nettype wire

// File: tb/tb_vexriscv_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vexriscv_io_bridge                                             |
// | Purpose : Self-checking bench for vexriscv_io_bridge. Register accesses    |
// |           come from a vector table and hand-written sequences; expected    |
// |           read data and UART TX bytes are queued when driven and checked   |
// |           when the bridge produces them. Timer checks follow the           |
// |           IO_BRIDGE_TIMER_EN build option.                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_vexriscv_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_wr;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        uart_tx_rdy, uart_tx_vld;
  logic [7:0]  uart_tx_data;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic [7:0]  gpio_out, gpio_in;
  logic [63:0] pwm_dcycle;
  logic        timer_irq;

  vexriscv_io_bridge dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .uart_tx_rdy(uart_tx_rdy), .uart_tx_vld(uart_tx_vld), .uart_tx_data(uart_tx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .gpio_out(gpio_out), .gpio_in(gpio_in),
    .pwm_dcycle(pwm_dcycle), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] rsp_exp[$];
  logic [7:0]  tx_exp[$];
  int tx_seen = 0;
  bit tx_auto = 0;
  int tx_busy = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response / TX-byte scoreboard and a simple uart_lite ready model
  always @(negedge clk) begin
    checks++;
    if (rsp_valid) begin
      if (rsp_exp.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got %0h expected none", rsp_data);
      end else begin
        logic [31:0] e;
        e = rsp_exp.pop_front();
        if (rsp_data !== e) begin
          errors++;
          $display("FAIL rsp_data got %0h expected %0h", rsp_data, e);
        end
      end
    end else if (rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL rsp_idle got %0h expected 0", rsp_data);
    end
    if (uart_tx_vld === 1'b1) begin
      checks++;
      tx_seen++;
      if (tx_exp.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %0h expected none", uart_tx_data);
      end else begin
        logic [7:0] t;
        t = tx_exp.pop_front();
        if (uart_tx_data !== t) begin
          errors++;
          $display("FAIL tx_data got %0h expected %0h", uart_tx_data, t);
        end
      end
    end
    if (tx_auto) begin
      if (uart_tx_vld === 1'b1) begin
        uart_tx_rdy = 1'b0;
        tx_busy = 3;
      end else if (tx_busy > 0) begin
        tx_busy--;
        if (tx_busy == 0) uart_tx_rdy = 1'b1;
      end
    end
  end

  // All bus tasks are entered at a negedge and return at the next negedge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] e);
    rsp_exp.push_back(e);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] a,
                              input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.exp = e;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    bit found;
    int cnt;
    reset = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0;
    uart_tx_rdy = 0; uart_rx_valid = 0; uart_rx_data = 0; gpio_in = 8'h3C;

`ifdef IO_BRIDGE_TIMER_EN
    vecs.push_back(mk(0, 5'd8,  0, 32'hFFFF_FFFF));
    vecs.push_back(mk(0, 5'd9,  0, 32'hFFFF_FFFF));
`else
    vecs.push_back(mk(0, 5'd8,  0, 32'h0));
    vecs.push_back(mk(1, 5'd10, 32'h1, 0));
    vecs.push_back(mk(0, 5'd6,  0, 32'h0));
`endif
    vecs.push_back(mk(0, 5'd7,  0, 32'h0));
    vecs.push_back(mk(0, 5'd10, 0, 32'h0));
    vecs.push_back(mk(0, 5'd1,  0, 32'h4000_0000));
    vecs.push_back(mk(0, 5'd2,  0, 32'h0));
    vecs.push_back(mk(0, 5'd3,  0, 32'h0));
    vecs.push_back(mk(1, 5'd0,  32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 5'd0,  0, 32'hDEAD_BEEF));
    vecs.push_back(mk(1, 5'd4,  32'hFFFF_FFA5, 0));
    vecs.push_back(mk(0, 5'd4,  0, 32'h0000_00A5));
    vecs.push_back(mk(0, 5'd5,  0, 32'h0000_003C));
    vecs.push_back(mk(1, 5'd13, 32'h0001_2345, 0));
    vecs.push_back(mk(0, 5'd13, 0, 32'h0000_2345));
    vecs.push_back(mk(1, 5'd31, 32'h55, 0));
    vecs.push_back(mk(0, 5'd31, 0, 32'h0));
    vecs.push_back(mk(0, 5'd15, 0, 32'h0));

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_tx_vld",    64'(uart_tx_vld), 0);
    chk("reset_tx_data",   64'(uart_tx_data), 0);
    chk("reset_gpio_out",  64'(gpio_out), 0);
    chk("reset_pwm",       pwm_dcycle, 0);
    chk("reset_irq",       64'(timer_irq), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else            bus_read(vecs[i].addr, vecs[i].exp);
    end
    idle(2);
    chk("pwm2_out",  64'(pwm_dcycle[47:32]), 64'h2345);
    chk("pwm_other", {pwm_dcycle[63:48], pwm_dcycle[31:0]}, 0);
    chk("gpio_out",  64'(gpio_out), 64'hA5);

    // TX: two bytes through a pulsing ready
    tx_auto = 1; uart_tx_rdy = 1'b1;
    tx_exp.push_back(8'h41); bus_write(5'd1, 32'h41);
    tx_exp.push_back(8'h42); bus_write(5'd1, 32'h42);
    for (int i = 0; i < 100 && tx_exp.size() != 0; i++) @(negedge clk);
    chk("tx_drain",  64'(tx_exp.size()), 0);
    chk("tx_pulses", 64'(tx_seen), 2);
    bus_read(5'd1, 32'h4000_0000);
    idle(6);
    tx_auto = 0; tx_busy = 0; uart_tx_rdy = 1'b0;

    // TX overflow: 17 writes with ready held low
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_exp.push_back(8'(8'h60 + i));
      bus_write(5'd1, 32'(8'h60 + i));
    end
    bus_read(5'd1, 32'h8000_0010);
    bus_read(5'd3, 32'h4000_0000);
    bus_read(5'd3, 32'h0);
    idle(1);

    // Reset while a transfer is starting
    uart_tx_rdy = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (uart_tx_vld) found = 1;
    end
    chk("tx_start_seen", 64'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("tx_vld_after_reset", 64'(uart_tx_vld), 0);
    tx_exp.delete();
    reset = 1'b0;
    idle(5);
    bus_read(5'd1, 32'h4000_0000);
    bus_read(5'd0, 32'h0);
    idle(1);
    chk("pwm_after_reset", pwm_dcycle, 0);
    uart_tx_rdy = 1'b0;

    // RX: 17 bytes into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) begin
      uart_rx_valid = 1'b1; uart_rx_data = 8'(i);
      @(negedge clk);
    end
    uart_rx_valid = 1'b0;
    bus_read(5'd3, 32'h8000_1000);
    bus_read(5'd3, 32'h0000_1000);
    // Push and pop in the same cycle at full
    rsp_exp.push_back(32'h8000_0001);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 5'd2;
    uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
    @(negedge clk);
    cmd_valid = 1'b0; uart_rx_valid = 1'b0;
    bus_read(5'd3, 32'h0000_1000);
    for (int i = 2; i <= 16; i++) bus_read(5'd2, 32'h8000_0000 | 32'(i));
    bus_read(5'd2, 32'h8000_0099);
    bus_read(5'd2, 32'h0);
    bus_read(5'd3, 32'h0);
    idle(2);

`ifdef IO_BRIDGE_TIMER_EN
    bus_write(5'd9, 32'h0);
    bus_write(5'd8, 32'd100);
    bus_write(5'd7, 32'h5);
    bus_write(5'd6, 32'h0);
    bus_read(5'd6, 32'h0);
    bus_write(5'd7, 32'h0);
    bus_read(5'd7, 32'h5);
    bus_write(5'd6, 32'h0);
    bus_write(5'd10, 32'h1);
    chk("irq_before", 64'(timer_irq), 0);
    cnt = 1;
    while (!timer_irq && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("irq_rise_cycle", 64'(cnt), 101);
    bus_write(5'd8, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("irq_drop", 64'(timer_irq), 0);
    bus_write(5'd9, 32'hFFFF_FFFF);
    bus_read(5'd8, 32'hFFFF_FFFF);
    bus_read(5'd9, 32'hFFFF_FFFF);
    bus_read(5'd10, 32'h1);
`else
    bus_write(5'd8, 32'h0);
    bus_write(5'd9, 32'h0);
    idle(3);
    chk("irq_disabled", 64'(timer_irq), 0);
    bus_read(5'd8, 32'h0);
    cnt = 0;
`endif
    idle(3);
    chk("rsp_queue_empty", 64'(rsp_exp.size()), 0);
    chk("tx_queue_empty",  64'(tx_exp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vexriscv_io_bridge
`default_nettype wire
